// File: rtl/fpga_robots_game_tm_arbiter.sv
// fpga_robots_game_tm_arbiter: round-robin tile map port arbiter with atomic lock and starvation override
module fpga_robots_game_tm_arbiter #(
  parameter int LOCK_MAX = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [12:0] a_adr,
  input  logic [7:0]  a_wrt,
  input  logic        a_wen,
  input  logic        a_lock,
  output logic        a_ack,
  output logic        a_rvalid,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic [12:0] b_adr,
  input  logic [7:0]  b_wrt,
  input  logic        b_wen,
  input  logic        b_lock,
  output logic        b_ack,
  output logic        b_rvalid,
  output logic [7:0]  b_rdata,
  output logic [12:0] tm_adr,
  output logic [7:0]  tm_wrt,
  output logic        tm_wen,
  input  logic [7:0]  tm_red,
  output logic        lock_ovf
);
  typedef enum logic [1:0] {NONE, OWN_A, OWN_B} owner_t;
  localparam logic [15:0] LMAX = 16'(LOCK_MAX);
  localparam bit OVR = LOCK_MAX != 0;
  owner_t owner, owner_nxt;
  logic pri_b;
  logic [15:0] a_cnt, b_cnt, a_cnt_nxt, b_cnt_nxt;
  logic a_el, b_el, a_blk, b_blk, a_frc, b_frc, a_ok, b_ok, gnt_a, gnt_b;
  logic [1:0] p_v, p_id;
  always_comb begin
    a_el = a_req & ~a_ack;
    b_el = b_req & ~b_ack;
    a_blk = (owner == OWN_B) & b_lock;
    b_blk = (owner == OWN_A) & a_lock;
    a_frc = OVR & a_el & a_blk & (a_cnt == LMAX);
    b_frc = OVR & b_el & b_blk & (b_cnt == LMAX);
    a_ok = a_el & (~a_blk | a_frc);
    b_ok = b_el & (~b_blk | b_frc);
    gnt_a = a_frc | (a_ok & ~b_frc & (~b_ok | ~pri_b));
    gnt_b = b_ok & ~gnt_a;
    owner_nxt = gnt_a ? OWN_A : gnt_b ? OWN_B : owner;
    a_cnt_nxt = (gnt_a | ~a_el) ? 16'd0 : (a_blk & (a_cnt != 16'hFFFF)) ? a_cnt + 16'd1 : a_cnt;
    b_cnt_nxt = (gnt_b | ~b_el) ? 16'd0 : (b_blk & (b_cnt != 16'hFFFF)) ? b_cnt + 16'd1 : b_cnt;
  end
  always_ff @(posedge clk) owner <= rst ? NONE : owner_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_b <= 1'b0;
      a_cnt <= '0;
      b_cnt <= '0;
      lock_ovf <= 1'b0;
      tm_adr <= '0;
      tm_wrt <= '0;
      tm_wen <= 1'b0;
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      p_v <= '0;
      p_id <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      pri_b <= gnt_a ? 1'b1 : gnt_b ? 1'b0 : pri_b;
      a_cnt <= a_cnt_nxt;
      b_cnt <= b_cnt_nxt;
      lock_ovf <= lock_ovf | a_frc | b_frc;
      a_ack <= gnt_a;
      b_ack <= gnt_b;
      tm_wen <= gnt_a ? a_wen : gnt_b & b_wen;
      if (gnt_a | gnt_b) begin
        tm_adr <= gnt_a ? a_adr : b_adr;
        tm_wrt <= gnt_a ? a_wrt : b_wrt;
      end
      p_v <= {p_v[0], gnt_a | gnt_b};
      p_id <= {p_id[0], gnt_b};
      a_rvalid <= p_v[1] & ~p_id[1];
      b_rvalid <= p_v[1] & p_id[1];
      if (p_v[1] & ~p_id[1]) a_rdata <= tm_red;
      if (p_v[1] & p_id[1]) b_rdata <= tm_red;
    end
  end
endmodule

// File: tb/tb_fpga_robots_game_tm_arbiter.sv
// tb_fpga_robots_game_tm_arbiter: directed and randomized checks of the tile map arbiter against a behavioural model
module tb_fpga_robots_game_tm_arbiter;
  localparam int LMAX = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic a_req = 1'b0, a_wen = 1'b0, a_lock = 1'b0, b_req = 1'b0, b_wen = 1'b0, b_lock = 1'b0;
  logic [12:0] a_adr = '0, b_adr = '0;
  logic [7:0] a_wrt = '0, b_wrt = '0;
  logic a_ack, a_rvalid, b_ack, b_rvalid, tm_wen, lock_ovf;
  logic [7:0] a_rdata, b_rdata, tm_wrt, tm_red;
  logic [12:0] tm_adr;
  logic z_a_ack, z_a_rvalid, z_b_ack, z_b_rvalid, z_tm_wen, z_lock_ovf;
  logic [7:0] z_a_rdata, z_b_rdata, z_tm_wrt;
  logic [12:0] z_tm_adr;
  fpga_robots_game_tm_arbiter #(.LOCK_MAX(LMAX)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_adr(a_adr), .a_wrt(a_wrt), .a_wen(a_wen), .a_lock(a_lock),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_adr(b_adr), .b_wrt(b_wrt), .b_wen(b_wen), .b_lock(b_lock),
    .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .tm_adr(tm_adr), .tm_wrt(tm_wrt), .tm_wen(tm_wen), .tm_red(tm_red), .lock_ovf(lock_ovf)
  );
  fpga_robots_game_tm_arbiter #(.LOCK_MAX(0)) dut0 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_adr(a_adr), .a_wrt(a_wrt), .a_wen(a_wen), .a_lock(a_lock),
    .a_ack(z_a_ack), .a_rvalid(z_a_rvalid), .a_rdata(z_a_rdata),
    .b_req(b_req), .b_adr(b_adr), .b_wrt(b_wrt), .b_wen(b_wen), .b_lock(b_lock),
    .b_ack(z_b_ack), .b_rvalid(z_b_rvalid), .b_rdata(z_b_rdata),
    .tm_adr(z_tm_adr), .tm_wrt(z_tm_wrt), .tm_wen(z_tm_wen), .tm_red(8'h00), .lock_ovf(z_lock_ovf)
  );
  always #5 clk = ~clk;
  logic [7:0] mem [8192];
  always @(posedge clk) begin
    if (tm_wen) mem[tm_adr] <= tm_wrt;
    tm_red <= tm_wen ? tm_wrt : mem[tm_adr];
  end
  typedef struct {int who; logic [7:0] data; int at;} ret_t;
  ret_t q[$];
  logic [7:0] m_mem [8192];
  int n = 0, errs = 0, checks = 0, m_owner, m_nxt;
  int m_cnt[2];
  bit m_ack[2], m_rv[2], m_ovf, m_wen;
  logic [7:0] m_rd[2], m_wrt;
  logic [12:0] m_adr;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, n);
    end
  endtask
  task automatic step();
    bit req[2], lk[2], wen[2], el[2], blk[2], frc[2], ok[2], r;
    logic [12:0] adr[2];
    logic [7:0] wrt[2];
    ret_t e;
    int g = -1;
    r = rst;
    req[0] = a_req; req[1] = b_req;
    lk[0] = a_lock; lk[1] = b_lock;
    wen[0] = a_wen; wen[1] = b_wen;
    adr[0] = a_adr; adr[1] = b_adr;
    wrt[0] = a_wrt; wrt[1] = b_wrt;
    for (int x = 0; x < 2; x++) begin
      el[x] = req[x] && !m_ack[x];
      blk[x] = (m_owner == 2 - x) && lk[1 - x];
      frc[x] = LMAX != 0 && el[x] && blk[x] && m_cnt[x] >= LMAX;
      ok[x] = el[x] && (!blk[x] || frc[x]);
    end
    if (frc[0]) g = 0;
    else if (frc[1]) g = 1;
    else if (ok[0] && ok[1]) g = m_nxt;
    else if (ok[0]) g = 0;
    else if (ok[1]) g = 1;
    @(posedge clk);
    #1;
    n++;
    if (r) begin
      m_owner = 0; m_nxt = 0; m_ovf = 0; m_wen = 0; m_adr = '0; m_wrt = '0;
      for (int x = 0; x < 2; x++) begin
        m_cnt[x] = 0; m_ack[x] = 0; m_rv[x] = 0; m_rd[x] = '0;
      end
      q.delete();
    end else begin
      for (int x = 0; x < 2; x++) begin
        if (g == x || !el[x]) m_cnt[x] = 0;
        else if (blk[x] && m_cnt[x] < 65535) m_cnt[x]++;
        m_ack[x] = (g == x);
        m_rv[x] = 0;
      end
      if (g >= 0 && frc[g]) m_ovf = 1;
      if (q.size() > 0 && q[0].at == n) begin
        m_rv[q[0].who] = 1;
        m_rd[q[0].who] = q[0].data;
        void'(q.pop_front());
      end
      m_wen = 0;
      if (g >= 0) begin
        m_adr = adr[g]; m_wrt = wrt[g]; m_wen = wen[g];
        if (wen[g]) m_mem[adr[g]] = wrt[g];
        e.who = g; e.data = m_mem[adr[g]]; e.at = n + 2;
        q.push_back(e);
        m_owner = g + 1;
        m_nxt = 1 - g;
      end
    end
    check("ack", {a_ack, b_ack}, {m_ack[0], m_ack[1]});
    check("ret", {a_rvalid, b_rvalid, a_rdata, b_rdata}, {m_rv[0], m_rv[1], m_rd[0], m_rd[1]});
    check("tm", {tm_wen, tm_wrt, tm_adr, lock_ovf}, {m_wen, m_wrt, m_adr, m_ovf});
  endtask
  task automatic acc(input int who, input logic [12:0] adr, input bit wen, input logic [7:0] wrt, output logic [7:0] rd);
    int k = 0;
    if (who == 0) begin a_req = 1; a_adr = adr; a_wen = wen; a_wrt = wrt; end
    else begin b_req = 1; b_adr = adr; b_wen = wen; b_wrt = wrt; end
    do begin step(); k++; end while (!(who == 0 ? a_ack : b_ack) && k < 20);
    check("acc_ack", who == 0 ? a_ack : b_ack, 1);
    check("acc_tm", {tm_wen, tm_adr}, {wen, adr});
    if (who == 0) begin a_req = 0; a_wen = 0; end
    else begin b_req = 0; b_wen = 0; end
    step();
    check("acc_wen_off", tm_wen, 0);
    step();
    check("acc_rv", who == 0 ? {a_rvalid, b_rvalid} : {b_rvalid, a_rvalid}, 2'b10);
    rd = who == 0 ? a_rdata : b_rdata;
  endtask
  initial begin
    logic [7:0] rd, v;
    logic [12:0] pa;
    int k;
    bit seen, between;
    for (int i = 0; i < 8192; i++) begin
      v = 8'($urandom);
      mem[i] = v;
      m_mem[i] = v;
    end
    step();
    step();
    check("rst", {a_ack, b_ack, a_rvalid, b_rvalid, a_rdata, b_rdata, tm_adr, tm_wrt, tm_wen, lock_ovf}, 0);
    check("rst_lm0", {z_a_ack, z_b_ack, z_a_rvalid, z_b_rvalid, z_a_rdata, z_b_rdata, z_tm_adr, z_tm_wrt, z_tm_wen, z_lock_ovf}, 0);
    rst = 0;
    mem[13'h105] = 8'h5A;
    m_mem[13'h105] = 8'h5A;
    acc(0, 13'h105, 0, 8'h00, rd);
    check("read_a", rd, 8'h5A);
    rst = 1; step(); rst = 0;
    a_req = 1; b_req = 1; a_adr = 13'h40; b_adr = 13'h80;
    for (int i = 0; i < 8; i++) begin
      step();
      check("alt", {a_ack, b_ack}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i > 0) check("tm_chg", tm_adr == pa, 0);
      pa = tm_adr;
      if (a_ack) a_adr = a_adr + 13'd1;
      if (b_ack) b_adr = b_adr + 13'd1;
    end
    a_req = 0; b_req = 0;
    repeat (3) step();
    mem[13'h200] = 8'h03;
    m_mem[13'h200] = 8'h03;
    b_req = 1; b_adr = 13'h300;
    a_req = 1; a_adr = 13'h200; a_wen = 0; a_lock = 1;
    k = 0;
    do begin
      step(); k++;
      if (b_ack) b_adr = b_adr + 13'd1;
    end while (!a_ack && k < 8);
    check("rmw_ack1", a_ack, 1);
    a_req = 0;
    between = 0;
    repeat (2) begin step(); between |= b_ack; end
    check("rmw_rd", {a_rvalid, a_rdata}, {1'b1, 8'h03});
    a_req = 1; a_wen = 1; a_wrt = a_rdata + 8'h10;
    step();
    between |= b_ack;
    check("rmw_ack2", a_ack, 1);
    check("rmw_no_b", between, 0);
    a_req = 0; a_wen = 0; a_lock = 0;
    step();
    check("rmw_b_after", b_ack, 1);
    b_req = 0;
    repeat (3) step();
    acc(0, 13'h200, 0, 8'h00, rd);
    check("rmw_final", rd, 8'h13);
    rst = 1; step(); rst = 0;
    a_lock = 1;
    acc(0, 13'h10, 0, 8'h00, rd);
    b_req = 1; b_adr = 13'h20;
    k = 0; seen = 0;
    do begin step(); k++; seen |= z_b_ack; end while (!b_ack && k < 40);
    check("starve_edges", k, 5);
    check("ovf", lock_ovf, 1);
    repeat (20) begin step(); seen |= z_b_ack; end
    check("ovf_sticky", lock_ovf, 1);
    check("lm0_never", seen, 0);
    check("lm0_ovf", z_lock_ovf, 0);
    b_req = 0; a_lock = 0;
    rst = 1; step(); rst = 0;
    a_req = 1; a_adr = 13'h105; a_wen = 0;
    k = 0;
    do begin step(); k++; end while (!a_ack && k < 20);
    check("mid_ack", a_ack, 1);
    a_req = 0;
    rst = 1; step(); rst = 0;
    repeat (3) begin step(); check("mid_norv", {a_rvalid, tm_wen}, 0); end
    a_req = 1; b_req = 1;
    step();
    check("post_rst_a", {a_ack, b_ack}, 2'b10);
    a_req = 0;
    step();
    check("post_rst_b", {a_ack, b_ack}, 2'b01);
    b_req = 0;
    repeat (3) step();
    acc(1, 13'h1234, 1, 8'hC7, rd);
    check("echo", rd, 8'hC7);
    acc(0, 13'h1234, 0, 8'h00, rd);
    check("echo_rd", rd, 8'hC7);
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      if (a_ack || !a_req) begin
        a_req = ($urandom_range(0, 3) != 0);
        a_adr = 13'($urandom_range(0, 31));
        a_wen = 1'($urandom_range(0, 1));
        a_wrt = 8'($urandom);
      end
      if (b_ack || !b_req) begin
        b_req = ($urandom_range(0, 3) != 0);
        b_adr = 13'($urandom_range(0, 31));
        b_wen = 1'($urandom_range(0, 1));
        b_wrt = 8'($urandom);
      end
      if ($urandom_range(0, 15) == 0) a_lock = !a_lock;
      if ($urandom_range(0, 15) == 0) b_lock = !b_lock;
      step();
    end
    rst = 0; a_req = 0; b_req = 0; a_lock = 0; b_lock = 0;
    repeat (4) step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
